// File: rtl/unshuffle_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// unshuffle_param
//
// Takes one IMG_W x IMG_W frame of pixels in raster order and scatters each
// pixel into a 4-bank SRAM image. Each SRAM word holds CH_NUM channels of one
// 2x2 activation tile. Two mappings are supported:
//   mode 0 : 2x2 pixel unshuffle. The pixel's position inside its 2x2 block
//            selects the channel, and the image is halved in each dimension.
//   mode 1 : pass-through. Every pixel goes to channel 0 at full resolution.
// Each accepted pixel produces exactly one masked single-activation write in
// the next cycle. All SRAM-side outputs come straight from flops.
//
// Ports
//   clk              : rising-edge clock
//   rst_n            : synchronous active-low reset
//   enable           : frame start, sampled only while idle
//   mode             : mapping select, latched together with enable
//   in_valid         : input_data carries a pixel this cycle
//   input_data       : pixel value, raster order from (0,0)
//   busy             : frame in progress (through the cycle of the last write)
//   valid            : one-cycle frame-done pulse, the cycle after the last write
//   sram_wen_a0..a3  : per-bank write enables, active-low
//   sram_wordmask_a  : per-activation mask, 0 = write that activation
//   sram_waddr_a     : word address shared by all banks
//   sram_wdata_a     : write data, activation 0 in the most significant slot
// -----------------------------------------------------------------------------
module unshuffle_param #(
    parameter int unsigned IMG_W        = 28,
    parameter int unsigned BW_PER_ACT   = 12,
    parameter int unsigned CH_NUM       = 4,
    parameter int unsigned ACT_PER_ADDR = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       enable,
    input  logic                                       mode,
    input  logic                                       in_valid,
    input  logic [BW_PER_ACT-1:0]                      input_data,
    output logic                                       busy,
    output logic                                       valid,
    output logic                                       sram_wen_a0,
    output logic                                       sram_wen_a1,
    output logic                                       sram_wen_a2,
    output logic                                       sram_wen_a3,
    output logic [CH_NUM*ACT_PER_ADDR-1:0]             sram_wordmask_a,
    output logic [5:0]                                 sram_waddr_a,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_wdata_a
);

    localparam int unsigned   CW       = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned   N_ACT    = CH_NUM * ACT_PER_ADDR;
    localparam int unsigned   WD_W     = N_ACT * BW_PER_ACT;
    localparam logic [CW-1:0] LAST_IDX = CW'(IMG_W - 1);
    // Tile words per tile-row: ceil(OW/4) for each mapping's output width.
    localparam logic [5:0]    NB_UNSH  = 6'((IMG_W / 2 + 3) / 4);
    localparam logic [5:0]    NB_PASS  = 6'((IMG_W + 3) / 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q,  mode_d;
    logic [CW-1:0]     row_q,   row_d;
    logic [CW-1:0]     col_q,   col_d;
    logic              busy_q,  busy_d;
    logic              valid_q, valid_d;
    logic [3:0]        wen_q,   wen_d;
    logic [N_ACT-1:0]  mask_q,  mask_d;
    logic [5:0]        waddr_q, waddr_d;
    logic [WD_W-1:0]   wdata_q, wdata_d;

    logic              accept;
    logic [CW-1:0]     y, x, ty, tx;
    logic [1:0]        ch, k, bank;
    logic [5:0]        nb, tile_addr;
    logic [3:0]        act_idx, slot;

    // -------------------------------------------------------------------------
    // Frame control and raster counters
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        row_d   = row_q;
        col_d   = col_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                    mode_d  = mode;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        if (row_q == LAST_IDX) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy covers LOAD and the DONE cycle, which carries the last write.
        busy_d  = (state_d != IDLE);
        // valid lands one cycle after DONE, i.e. in the first idle cycle,
        // where a new enable may already be accepted.
        valid_d = (state_q == DONE);
    end

    // -------------------------------------------------------------------------
    // Pixel -> (bank, address, activation slot) mapping
    // -------------------------------------------------------------------------
    always_comb begin
        if (!mode_q) begin
            // Position within the 2x2 pixel block picks the channel.
            ch = {row_q[0], col_q[0]};
            y  = row_q >> 1;
            x  = col_q >> 1;
            nb = NB_UNSH;
        end else begin
            ch = 2'b00;
            y  = row_q;
            x  = col_q;
            nb = NB_PASS;
        end

        ty        = y >> 1;
        tx        = x >> 1;
        k         = {y[0], x[0]};
        // Tiles checkerboard across the four banks, so each bank sees every
        // other tile in both directions.
        bank      = {ty[0], tx[0]};
        tile_addr = 6'(ty >> 1) * nb + 6'(tx >> 1);

        act_idx   = {ch, k};
        // Activation 0 lives in the most significant slot of the word.
        slot      = 4'(N_ACT - 1) - act_idx;
    end

    // -------------------------------------------------------------------------
    // Next SRAM write (registered below, so it appears the cycle after accept)
    // -------------------------------------------------------------------------
    always_comb begin
        wen_d   = '1;
        mask_d  = '1;
        waddr_d = '0;
        wdata_d = '0;
        if (accept) begin
            wen_d   = ~(4'b0001 << bank);
            mask_d  = ~(N_ACT'(1'b1) << slot);
            waddr_d = tile_addr;
            wdata_d = WD_W'(input_data) << (slot * BW_PER_ACT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            wen_q   <= '1;
            mask_q  <= '1;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            wen_q   <= wen_d;
            mask_q  <= mask_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy            = busy_q;
    assign valid           = valid_q;
    assign sram_wen_a0     = wen_q[0];
    assign sram_wen_a1     = wen_q[1];
    assign sram_wen_a2     = wen_q[2];
    assign sram_wen_a3     = wen_q[3];
    assign sram_wordmask_a = mask_q;
    assign sram_waddr_a    = waddr_q;
    assign sram_wdata_a    = wdata_q;

endmodule

// File: tb/tb_unshuffle_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_unshuffle_param
//
// Drives whole frames into unshuffle_param, records every SRAM write, and
// compares selected writes against a hand-computed vector table, every write
// against an arithmetic reference model, and the frame-level handshake
// (busy / valid / reset abort) against hand-written cycle sequences.
// -----------------------------------------------------------------------------
module tb_unshuffle_param;

    localparam int unsigned IMG_W = 28;
    localparam int unsigned BW    = 12;
    localparam int          NPIX  = 784;
    localparam int          MAXW  = 8192;

    logic         clk = 1'b0;
    logic         rst_n, enable, mode, in_valid;
    logic [11:0]  input_data;
    logic         busy, valid;
    logic         wen0, wen1, wen2, wen3;
    logic [15:0]  wmask;
    logic [5:0]   waddr;
    logic [191:0] wdata;

    always #5 clk = ~clk;

    unshuffle_param #(
        .IMG_W        (IMG_W),
        .BW_PER_ACT   (BW),
        .CH_NUM       (4),
        .ACT_PER_ADDR (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .mode            (mode),
        .in_valid        (in_valid),
        .input_data      (input_data),
        .busy            (busy),
        .valid           (valid),
        .sram_wen_a0     (wen0),
        .sram_wen_a1     (wen1),
        .sram_wen_a2     (wen2),
        .sram_wen_a3     (wen3),
        .sram_wordmask_a (wmask),
        .sram_waddr_a    (waddr),
        .sram_wdata_a    (wdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] pix_data(input int n);
        return 12'(n + 32'h123);
    endfunction

    // Reference mapping written straight from the pixel/tile arithmetic.
    function automatic logic [217:0] model(input bit m, input int n);
        int r, c, ch, y, x, ow, nb, ty, tx, k, bank, addr, i;
        logic [3:0]   w;
        logic [15:0]  mk;
        logic [191:0] d;
        r = n / int'(IMG_W);
        c = n % int'(IMG_W);
        if (!m) begin
            ch = (r % 2) * 2 + (c % 2); y = r / 2; x = c / 2; ow = int'(IMG_W) / 2;
        end else begin
            ch = 0; y = r; x = c; ow = int'(IMG_W);
        end
        nb   = (ow + 3) / 4;
        ty   = y / 2;
        tx   = x / 2;
        k    = (y % 2) * 2 + (x % 2);
        bank = (ty % 2) * 2 + (tx % 2);
        addr = (ty / 2) * nb + tx / 2;
        i    = ch * 4 + k;
        w    = ~(4'b0001 << bank);
        mk   = ~(16'h0001 << (15 - i));
        d    = 192'(pix_data(n)) << ((15 - i) * 12);
        return {w, 6'(addr), mk, d};
    endfunction

    // ---------------- write monitor ----------------
    logic [3:0]   wr_wen  [MAXW];
    logic [5:0]   wr_addr [MAXW];
    logic [15:0]  wr_mask [MAXW];
    logic [191:0] wr_data [MAXW];
    int wr_total    = 0;
    int idle_viol   = 0;
    int multi_viol  = 0;
    int valid_total = 0;

    always @(negedge clk) begin
        if ({wen3, wen2, wen1, wen0} != 4'hF) begin
            if ($countones(~{wen3, wen2, wen1, wen0}) != 1) multi_viol++;
            if (wr_total < MAXW) begin
                wr_wen[wr_total]  = {wen3, wen2, wen1, wen0};
                wr_addr[wr_total] = waddr;
                wr_mask[wr_total] = wmask;
                wr_data[wr_total] = wdata;
            end
            wr_total++;
        end else if (wmask != 16'hFFFF || waddr != 6'd0 || wdata != 192'd0) begin
            idle_viol++;
        end
        if (valid === 1'b1) valid_total++;
    end

    // ---------------- frame driver ----------------
    task automatic run_frame(input bit m, input int gap_pct, input int abort_at,
                             input bit started, input bit chain, input bit next_m,
                             output int base);
        int pix;
        bit aborted;
        int vb;
        aborted = 1'b0;
        if (!started) begin
            enable = 1'b1;
            mode   = m;
            @(posedge clk); #1;
            enable = 1'b0;
        end
        mode = ~m;   // must not affect the latched mapping
        base = wr_total;
        pix  = 0;
        while (pix < NPIX && !aborted) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid   = 1'b0;
                input_data = 12'hFFF;
            end else begin
                in_valid   = 1'b1;
                input_data = pix_data(pix);
                pix++;
            end
            enable = (gap_pct > 0) ? 1'($urandom_range(1)) : 1'b0;
            @(posedge clk); #1;
            if (abort_at > 0 && in_valid && pix == abort_at) aborted = 1'b1;
        end
        in_valid   = 1'b0;
        input_data = '0;
        enable     = 1'b0;

        if (aborted) begin
            vb    = valid_total;
            rst_n = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            check("abort_reset_outputs",
                  256'({busy, valid, wen3, wen2, wen1, wen0, wmask, waddr, wdata}),
                  256'({1'b0, 1'b0, 4'hF, 16'hFFFF, 6'd0, 192'd0}));
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            check("abort_write_count", 256'(wr_total - base), 256'(abort_at));
            check("abort_no_valid", 256'(valid_total), 256'(vb));
        end else begin
            // Cycle after the last acceptance: last write, still busy.
            @(negedge clk);
            check("last_write_cycle",
                  256'({busy, valid, ({wen3, wen2, wen1, wen0} != 4'hF)}), 256'(3'b101));
            @(posedge clk); #1;
            if (chain) begin
                enable = 1'b1;
                mode   = next_m;
            end
            @(negedge clk);
            check("valid_pulse", 256'({busy, valid}), 256'(2'b01));
            check("frame_write_count", 256'(wr_total - base), 256'(NPIX));
            for (int n = 0; n < NPIX && base + n < MAXW; n++) begin
                check($sformatf("frame_word[%0d]", n),
                      256'({wr_wen[base+n], wr_addr[base+n], wr_mask[base+n], wr_data[base+n]}),
                      256'(model(m, n)));
            end
            @(posedge clk); #1;
            enable = 1'b0;
            @(negedge clk);
            check("valid_one_cycle", 256'(valid), 256'(1'b0));
        end
    endtask

    // ---------------- hand-computed vector table ----------------
    typedef struct {
        bit          m;
        int          r;
        int          c;
        logic [3:0]  wen;     // {a3,a2,a1,a0}
        logic [5:0]  addr;
        logic [15:0] mask;
        logic [11:0] d;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit m, input int r, input int c, input logic [3:0] w,
                                input logic [5:0] a, input logic [15:0] mk_, input logic [11:0] d,
                                input string name);
        vec_t v;
        v.m = m; v.r = r; v.c = c; v.wen = w; v.addr = a; v.mask = mk_; v.d = d; v.name = name;
        return v;
    endfunction

    function automatic logic [191:0] place(input logic [15:0] msk, input logic [11:0] d);
        logic [191:0] w;
        w = '0;
        for (int p = 0; p < 16; p++)
            if (!msk[p]) w = 192'(d) << (p * 12);
        return w;
    endfunction

    int base_a, base_b, base_c, base_d, base_e, base_f;

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; in_valid = 1'b0; input_data = '0;

        vecs.push_back(mk(0,  0,  0, 4'b1110, 6'd0,  16'h7FFF, 12'h123, "m0_r0c0"));
        vecs.push_back(mk(0,  0,  1, 4'b1110, 6'd0,  16'hF7FF, 12'h124, "m0_r0c1"));
        vecs.push_back(mk(0,  1,  1, 4'b1110, 6'd0,  16'hFFF7, 12'h140, "m0_r1c1"));
        vecs.push_back(mk(0,  0,  2, 4'b1110, 6'd0,  16'hBFFF, 12'h125, "m0_r0c2"));
        vecs.push_back(mk(0,  0,  4, 4'b1101, 6'd0,  16'h7FFF, 12'h127, "m0_r0c4"));
        vecs.push_back(mk(0, 27, 27, 4'b1110, 6'd15, 16'hFFFE, 12'h432, "m0_r27c27"));
        vecs.push_back(mk(0,  2,  0, 4'b1110, 6'd0,  16'hDFFF, 12'h15B, "m0_r2c0"));
        vecs.push_back(mk(0,  4,  0, 4'b1011, 6'd0,  16'h7FFF, 12'h193, "m0_r4c0"));
        vecs.push_back(mk(0,  8,  0, 4'b1110, 6'd4,  16'h7FFF, 12'h203, "m0_r8c0"));
        vecs.push_back(mk(0,  0, 16, 4'b1110, 6'd2,  16'h7FFF, 12'h133, "m0_r0c16"));
        vecs.push_back(mk(1,  0,  2, 4'b1101, 6'd0,  16'h7FFF, 12'h125, "m1_r0c2"));
        vecs.push_back(mk(1, 27, 27, 4'b0111, 6'd48, 16'hEFFF, 12'h432, "m1_r27c27"));
        vecs.push_back(mk(1,  0,  1, 4'b1110, 6'd0,  16'hBFFF, 12'h124, "m1_r0c1"));
        vecs.push_back(mk(1,  1,  0, 4'b1110, 6'd0,  16'hDFFF, 12'h13F, "m1_r1c0"));
        vecs.push_back(mk(1,  1,  1, 4'b1110, 6'd0,  16'hEFFF, 12'h140, "m1_r1c1"));
        vecs.push_back(mk(1,  2,  0, 4'b1011, 6'd0,  16'h7FFF, 12'h15B, "m1_r2c0"));
        vecs.push_back(mk(1,  0,  4, 4'b1110, 6'd1,  16'h7FFF, 12'h127, "m1_r0c4"));
        vecs.push_back(mk(1,  4,  4, 4'b1110, 6'd8,  16'h7FFF, 12'h197, "m1_r4c4"));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  256'(busy),  256'(1'b0));
        check("rst_valid", 256'(valid), 256'(1'b0));
        check("rst_wen",   256'({wen3, wen2, wen1, wen0}), 256'(4'hF));
        check("rst_mask",  256'(wmask), 256'(16'hFFFF));
        check("rst_addr",  256'(waddr), 256'(6'd0));
        check("rst_data",  256'(wdata), 256'(192'd0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mode 0 frame chained back-to-back into a mode 1 frame
        run_frame(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, base_a);
        run_frame(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, base_b);

        foreach (vecs[j]) begin
            int n;
            n = (vecs[j].m ? base_b : base_a) + vecs[j].r * int'(IMG_W) + vecs[j].c;
            check(vecs[j].name,
                  256'({wr_wen[n], wr_addr[n], wr_mask[n], wr_data[n]}),
                  256'({vecs[j].wen, vecs[j].addr, vecs[j].mask, place(vecs[j].mask, vecs[j].d)}));
        end

        // Random input gaps, both mappings
        run_frame(1'b0, 50, 0, 1'b0, 1'b0, 1'b0, base_c);
        run_frame(1'b1, 50, 0, 1'b0, 1'b0, 1'b0, base_d);

        // Reset mid-frame, then a clean frame
        run_frame(1'b0, 50, 300, 1'b0, 1'b0, 1'b0, base_e);
        @(posedge clk); #1;
        run_frame(1'b0, 50, 0, 1'b0, 1'b0, 1'b0, base_f);

        check("idle_outputs_clean", 256'(idle_viol),   256'(0));
        check("single_bank_write",  256'(multi_viol),  256'(0));
        check("valid_pulse_total",  256'(valid_total), 256'(5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
